pad_frame_ctrl: RTL and testbench
=================================

Name: pad_frame_ctrl

Overview:
- Sequencer for the zero-padding engine in the canny pre-filter path; runs NUM_FRAMES padded frames back-to-back after one start pulse (e.g. one per channel).
- Owns the padding engine's ena/clear and the raw-pixel FIFO pop.
- Stalls the engine on upstream underflow or downstream backpressure, so the padded stream never contains bubbles of wrong data.

Parameters:
- FMAP_SIZE, 28: unpadded feature-map side length in pixels.
- N, 1: pad width on each side, in pixels; 0 is legal.
- NUM_FRAMES, 3: frames per start command; must be 1 or more.

Ports:
- clk  in  1: clock.
- rst_n  in  1: asynchronous active-low reset.
- start  in  1: one-cycle command; sampled only in IDLE.
- abort  in  1: synchronous abort; takes priority over all other events.
- src_valid  in  1: raw FIFO not empty.
- dst_ready  in  1: downstream can accept a padded pixel this cycle.
- pad_done  in  1: padding engine done flag; used only under the optional feature.
- pad_ena  out  1: padding engine enable, one padded pixel per asserted cycle.
- pad_clear  out  1: padding engine counter clear.
- src_rd  out  1: raw FIFO pop.
- busy  out  1: high in every state except IDLE.
- frame_idx  out  clog2(NUM_FRAMES+1): index of the frame in progress.
- all_done  out  1: one-cycle pulse after the last frame.
- err  out  1: sticky error flag (optional feature).

Behaviour:
- Reset values: all outputs 0, state IDLE, internal row/col counters 0.
- P = (FMAP_SIZE+2N)^2 positions per frame.
- Internal mirror counters: col c and row r in 0..FMAP_SIZE+2N-1.
  - Advance only on pad_ena.
  - c wraps at FMAP_SIZE+2N-1 and increments r at the wrap.
- need_raw, for N>=1: r in [N, FMAP_SIZE+N-1] and c in [N-1, FMAP_SIZE+N-2].
  - This is the engine's one-cycle-early read window.
- need_raw, for N=0: always 1.
- States:
  - IDLE: start=1 -> CLR. start while busy is ignored.
  - CLR: pad_clear=1 for exactly one cycle; r and c reset to 0 -> RUN.
  - RUN: pad_ena = dst_ready & (~need_raw | src_valid); src_rd = pad_ena & need_raw.
    - On pad_ena at r=c=FMAP_SIZE+2N-1 (last position), if frame_idx == NUM_FRAMES-1 -> DONE.
    - Otherwise frame_idx increments and the next state is CLR.
  - DONE: all_done=1 for one cycle; frame_idx cleared -> IDLE.
- pad_ena, src_rd and pad_clear are combinational from state, counters and inputs; they are 0 outside the states named above.
- Unstalled frame length: P cycles of RUN plus 1 CLR cycle. FMAP_SIZE*FMAP_SIZE src_rd per frame, never more.
- Stall:
  - dst_ready=0 freezes the counters, with pad_ena=0 and src_rd=0.
  - src_valid=0 stalls only positions where need_raw=1; pad-only positions proceed.
- abort in any non-IDLE state:
  - Same cycle: pad_ena=0, src_rd=0, pad_clear=1.
  - Next cycle: state IDLE, counters 0, frame_idx 0, all_done not pulsed.
  - abort in IDLE: pad_clear=1 for that cycle, no other effect.
- start and abort in the same cycle: abort wins; the block stays in IDLE.
- Asynchronous reset mid-frame: immediate return to the reset values. The FIFO and engine are expected to be reset by the same rst_n.

Optional Feature:
- Macro: PAD_FRAME_CTRL_CHECK_EN.
- Defined:
  - err sets when pad_done=1 while (pad_ena=0 or position != P-1).
  - err also sets when the last position is consumed without pad_done=1.
  - err clears only on rst_n.
- Undefined: err tied 0; pad_done ignored.

Test Plan:
1. FMAP_SIZE=4, N=1, NUM_FRAMES=1, src_valid=1, dst_ready=1, start pulse -> pad_clear 1 cycle, then pad_ena high 36 consecutive cycles with exactly 16 src_rd, then all_done 1 cycle, busy low after.
2. NUM_FRAMES=3, same config -> three CLR+36-cycle frames, frame_idx 0,1,2, 48 src_rd total, a single all_done at cycle 112 after the start pulse.
3. src_valid=0 for 5 cycles at first need_raw position (r=1, c=0) -> pad_ena and src_rd low those 5 cycles, frame completes in 41 RUN cycles; at a pad-only position (r=0) src_valid=0 has no effect.
4. dst_ready toggling 1/0 every cycle -> counters advance only on ready cycles, frame completes in 72 RUN cycles, 16 src_rd.
5. abort at RUN position 20 of frame 1, same cycle as start -> pad_clear=1 that cycle, IDLE next, frame_idx=0, no all_done; new start runs a full frame 0.
6. With PAD_FRAME_CTRL_CHECK_EN: force pad_done=1 at position 10 -> err=1 and stays 1 until rst_n; without the macro err stays 0.

Source files
------------

// File: rtl/pad_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pad_frame_ctrl
// Description : Frame sequencer for the zero-padding engine in the canny
//               pre-filter path. One start command runs NUM_FRAMES padded
//               frames back-to-back. The block drives the engine's enable
//               and clear and pops the raw-pixel FIFO. It stalls on upstream
//               underflow or downstream backpressure, so the padded stream
//               never carries a stale pixel.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   FMAP_SIZE  - unpadded feature-map side length in pixels
//   N          - pad width on each side in pixels (0 allowed)
//   NUM_FRAMES - frames per start command (>= 1)
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - one-cycle command, honoured only when idle
//   abort       - synchronous abort, highest priority
//   src_valid   - raw FIFO not empty
//   dst_ready   - downstream accepts a padded pixel this cycle
//   pad_done    - engine done flag (checked only with the check option)
//   pad_ena     - engine enable, one padded pixel per asserted cycle
//   pad_clear   - engine counter clear
//   src_rd      - raw FIFO pop
//   busy        - high whenever not idle
//   frame_idx   - index of the frame in progress
//   all_done    - one-cycle pulse after the last frame
//   err         - sticky protocol error flag
// Build option:
//   PAD_FRAME_CTRL_CHECK_EN - when defined, err checks pad_done against the
//   position mirror; when undefined, err is tied 0 and pad_done is ignored.
// ============================================================================
module pad_frame_ctrl #(
    parameter int FMAP_SIZE  = 28,
    parameter int N          = 1,
    parameter int NUM_FRAMES = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              src_valid,
    input  logic                              dst_ready,
    input  logic                              pad_done,
    output logic                              pad_ena,
    output logic                              pad_clear,
    output logic                              src_rd,
    output logic                              busy,
    output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_idx,
    output logic                              all_done,
    output logic                              err
);

    localparam int SIDE = FMAP_SIZE + 2 * N;
    localparam int CW   = (SIDE > 1) ? $clog2(SIDE) : 1;
    localparam int CW1  = CW + 1;
    localparam int FW   = $clog2(NUM_FRAMES + 1);

    localparam logic [CW-1:0] POS_LAST   = CW'(SIDE - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [FW-1:0]   frame_q, frame_d;

    logic            need_raw;
    logic            w_last;

    assign w_last = (row_q == POS_LAST) && (col_q == POS_LAST);

    // Raw-read window of the engine. It is the unpadded region shifted one
    // column early, because the engine fetches a raw pixel one cycle ahead
    // of emitting it. The range tests are offset subtractions in one extra
    // bit. A position below the lower bound wraps to a large value, so each
    // range needs only one unsigned compare.
    generate
        if (N == 0) begin : g_need_all
            assign need_raw = 1'b1;
        end else begin : g_need_win
            logic [CW1-1:0] w_row_off;
            logic [CW1-1:0] w_col_off;
            assign w_row_off = {1'b0, row_q} - CW1'(N);
            assign w_col_off = {1'b0, col_q} - CW1'(N - 1);
            assign need_raw  = (w_row_off < CW1'(FMAP_SIZE)) &&
                               (w_col_off < CW1'(FMAP_SIZE));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        frame_d   = frame_q;
        pad_ena   = 1'b0;
        src_rd    = 1'b0;
        pad_clear = 1'b0;
        all_done  = 1'b0;

        if (abort) begin
            // Clearing the engine on abort leaves it consistent with the
            // zeroed mirror counters.
            pad_clear = 1'b1;
            state_d   = S_IDLE;
            row_d     = '0;
            col_d     = '0;
            frame_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CLR;
                    end
                end
                S_CLR: begin
                    pad_clear = 1'b1;
                    row_d     = '0;
                    col_d     = '0;
                    state_d   = S_RUN;
                end
                S_RUN: begin
                    // Pad-only positions need no raw data, so only
                    // backpressure can stall them.
                    pad_ena = dst_ready & (~need_raw | src_valid);
                    src_rd  = pad_ena & need_raw;
                    if (pad_ena) begin
                        if (col_q == POS_LAST) begin
                            col_d = '0;
                            row_d = (row_q == POS_LAST) ? '0 : row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        if (w_last) begin
                            if (frame_q == FRAME_LAST) begin
                                state_d = S_DONE;
                            end else begin
                                frame_d = frame_q + 1'b1;
                                state_d = S_CLR;
                            end
                        end
                    end
                end
                S_DONE: begin
                    all_done = 1'b1;
                    frame_d  = '0;
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign frame_idx = frame_q;

`ifdef PAD_FRAME_CTRL_CHECK_EN
    // pad_done must coincide exactly with consumption of the last position.
    // A mismatch in either direction sets the flag.
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (pad_done ^ (pad_ena & w_last)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic w_unused_pad_done;
    assign w_unused_pad_done = pad_done;
    assign err               = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pad_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_frame_ctrl
// Description : Self-checking bench for pad_frame_ctrl. A driver issues
//               stimulus and pushes the expected per-cycle response of a
//               position-indexed reference model into a scoreboard queue. A
//               monitor pops and compares it against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_frame_ctrl;

    localparam int F    = 4;
    localparam int NP   = 1;
    localparam int NF   = 3;
    localparam int SIDE = F + 2 * NP;
    localparam int P    = SIDE * SIDE;
    localparam int FW   = $clog2(NF + 1);
`ifdef PAD_FRAME_CTRL_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic src_valid = 1'b0;
    logic dst_ready = 1'b0;
    logic pad_done = 1'b0;
    logic pad_ena, pad_clear, src_rd, busy, all_done, err;
    logic [FW-1:0] frame_idx;

    pad_frame_ctrl #(.FMAP_SIZE(F), .N(NP), .NUM_FRAMES(NF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .src_valid (src_valid),
        .dst_ready (dst_ready),
        .pad_done  (pad_done),
        .pad_ena   (pad_ena),
        .pad_clear (pad_clear),
        .src_rd    (src_rd),
        .busy      (busy),
        .frame_idx (frame_idx),
        .all_done  (all_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ena, rd, clr, bsy, done, er;
        int   fi;
        bit   mark;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cnt_rd = 0, cnt_ena = 0, cnt_clr = 0, cnt_done = 0, done_cyc = -1, mcyc = 0;

    // Reference model. m_pos is a linear position: -1 is the clear cycle,
    // 0..P-1 are padded positions, and P is the completion cycle.
    bit m_busy = 1'b0;
    int m_pos = 0;
    int m_frame = 0;
    bit m_err = 1'b0;
    int mode = 0;
    int cyc = 0;
    int hold = 0;
    bit inject = 1'b0;

    // A raw pixel is needed where the emitted pixel lies in the unpadded
    // image shifted one column right (the engine reads one cycle early).
    function automatic bit need_raw(input int pos);
        int r, c;
        r = pos / SIDE;
        c = pos % SIDE;
        if (NP == 0) return 1'b1;
        return (r >= NP) && (r < F + NP) && (c + 1 >= NP) && (c + 1 < F + NP);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
        end
    endtask

    task automatic step(input bit st, input bit ab, input bit mk);
        exp_t e;
        bit sv, dr, pd, in_run, last, nr;
        @(posedge clk);
        #2;
        cyc++;
        in_run = m_busy && (m_pos >= 0) && (m_pos < P);
        case (mode)
            0: begin sv = 1'b1; dr = 1'b1; end
            1: begin
                dr = 1'b1;
                sv = 1'b1;
                if (in_run && m_pos < SIDE) sv = 1'b0;
                else if (in_run && m_pos == SIDE && hold < 5) begin sv = 1'b0; hold++; end
            end
            2: begin sv = 1'b1; dr = ((cyc % 2) == 0); end
            default: begin
                sv = ($urandom % 10) < 7;
                dr = ($urandom % 4) != 0;
            end
        endcase
        nr   = in_run ? need_raw(m_pos) : 1'b0;
        last = in_run && (m_pos == P - 1);

        e.ena = 0; e.rd = 0; e.clr = 0; e.done = 0;
        e.bsy = m_busy; e.er = m_err; e.fi = m_busy ? m_frame : 0; e.mark = mk;
        if (!m_busy)            e.clr = ab;
        else if (ab)            e.clr = 1;
        else if (m_pos == -1)   e.clr = 1;
        else if (m_pos == P)    e.done = 1;
        else begin
            e.ena = dr && (!nr || sv);
            e.rd  = e.ena && nr;
        end
        if (ab) e.ena = 0;
        if (ab) e.rd = 0;

`ifdef PAD_FRAME_CTRL_CHECK_EN
        pd = (e.ena && last) || (inject && in_run && m_pos == 10);
        if (pd ^ (e.ena && last)) m_err = 1'b1;
`else
        pd = $urandom % 2;
`endif
        start = st; abort = ab; src_valid = sv; dst_ready = dr; pad_done = pd;
        sb.push_back(e);

        if (!m_busy) begin
            if (st && !ab) begin m_busy = 1; m_pos = -1; m_frame = 0; end
        end else if (ab) begin
            m_busy = 0; m_frame = 0; m_pos = 0;
        end else if (m_pos == -1) begin
            m_pos = 0;
        end else if (m_pos == P) begin
            m_busy = 0; m_frame = 0; m_pos = 0;
        end else if (e.ena) begin
            if (m_pos == P - 1) begin
                if (m_frame == NF - 1) m_pos = P;
                else begin m_frame++; m_pos = -1; end
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic settle();
        step(0, 0, 0);
        step(0, 0, 0);
        @(negedge clk);
        #1;
    endtask

    task automatic run_cmd(input int limit);
        step(1, 0, 1);
        for (int i = 0; i < limit && m_busy; i++) step(0, 0, 0);
        if (m_busy) begin
            checks++; errors++;
            $display("FAIL run_timeout actual=busy expected=idle");
        end
        settle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        start = 0; abort = 0; pad_done = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ena", pad_ena, 0);
        chk("rst_clr", pad_clear, 0);
        chk("rst_rd", src_rd, 0);
        chk("rst_fi", frame_idx, 0);
        chk("rst_done", all_done, 0);
        chk("rst_err", err, 0);
        m_busy = 0; m_pos = 0; m_frame = 0; m_err = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every presented output cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.mark) begin
                    cnt_rd = 0; cnt_ena = 0; cnt_clr = 0; cnt_done = 0; done_cyc = -1; mcyc = 0;
                end
                checks++;
                if (pad_ena !== e.ena || src_rd !== e.rd || pad_clear !== e.clr ||
                    busy !== e.bsy || all_done !== e.done || err !== e.er ||
                    frame_idx !== FW'(e.fi)) begin
                    errors++;
                    $display("FAIL outputs t=%0t actual ena=%b rd=%b clr=%b busy=%b done=%b err=%b fi=%0d expected ena=%b rd=%b clr=%b busy=%b done=%b err=%b fi=%0d",
                             $time, pad_ena, src_rd, pad_clear, busy, all_done, err, frame_idx,
                             e.ena, e.rd, e.clr, e.bsy, e.done, e.er, e.fi);
                end
                if (src_rd === 1'b1)    cnt_rd++;
                if (pad_ena === 1'b1)   cnt_ena++;
                if (pad_clear === 1'b1) cnt_clr++;
                if (all_done === 1'b1) begin cnt_done++; done_cyc = mcyc; end
                mcyc++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        bit b;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_ena", pad_ena, 0);
        chk("reset_clr", pad_clear, 0);
        chk("reset_rd", src_rd, 0);
        chk("reset_fi", frame_idx, 0);
        chk("reset_done", all_done, 0);
        chk("reset_err", err, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Three unstalled frames.
        mode = 0;
        run_cmd(400);
        chk("full_done_cnt", cnt_done, 1);
        chk("full_done_cyc", done_cyc, 112);
        chk("full_rd", cnt_rd, 48);
        chk("full_ena", cnt_ena, 108);
        chk("full_clr", cnt_clr, 3);
        chk("full_busy_after", busy, 0);

        // Underflow on row 0 (pad only) and 5 cycles at the first raw position.
        mode = 1; hold = 0;
        run_cmd(400);
        chk("uflow_done_cyc", done_cyc, 117);
        chk("uflow_rd", cnt_rd, 48);
        chk("uflow_ena", cnt_ena, 108);

        // Alternating backpressure.
        mode = 2;
        run_cmd(600);
        chk("bp_done_cnt", cnt_done, 1);
        chk("bp_rd", cnt_rd, 48);
        chk("bp_ena", cnt_ena, 108);

        // Abort with start at frame 1 position 20.
        mode = 0;
        step(1, 0, 1);
        b = 1'b0;
        for (int i = 0; i < 200; i++) begin
            b = m_busy && (m_frame == 1) && (m_pos == 20);
            step(b, b, 0);
            if (b) break;
        end
        if (!b) begin
            checks++; errors++;
            $display("FAIL abort_point actual=not_reached expected=reached");
        end
        settle();
        chk("abort_done_cnt", cnt_done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_fi", frame_idx, 0);
        step(0, 1, 0);
        run_cmd(400);
        chk("restart_done_cyc", done_cyc, 112);
        chk("restart_rd", cnt_rd, 48);

        // Randomized traffic with random start/abort.
        mode = 3;
        for (int i = 0; i < 3000; i++) step(($urandom % 16) == 0, ($urandom % 200) == 0, 0);

        // Asynchronous reset in the middle of a frame.
        mode = 0;
        step(1, 0, 0);
        for (int i = 0; i < 20 && !(m_busy && m_pos > 3); i++) step(0, 0, 0);
        settle();
        step(1, 0, 0);
        repeat (8) step(0, 0, 0);
        do_reset();

        // Spurious pad_done at position 10.
        inject = 1'b1;
        run_cmd(400);
        inject = 1'b0;
        chk("chk_err_set", err, EXP_ERR);
        settle();
        chk("chk_err_sticky", err, EXP_ERR);
        do_reset();
        settle();
        chk("chk_err_after_rst", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
